// File: rtl/ifq_pkg.sv
// Shared widths, fetch tag and FSM state type for the instruction-fetch queue.
package ifq_pkg;

  localparam int INS_W = 16;
  localparam int PC_W  = 16;

  typedef struct packed {
    logic            valid;
    logic            epoch;
    logic [PC_W-1:0] pc;
  } ifq_tag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Small register-based FIFO of {ins, pc}; head is read straight from storage.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues reads, absorbs MEM_LAT latency, queues words for decode.
// Define IFQ_BYPASS_EN to forward a returning word straight to decode when the queue is empty.
//
// state  | meaning
// IDLE   | first cycle after reset release, no reads issued
// RUN    | issuing reads while credit is available
// HALTED | no new reads, in-flight words still drain; left only by reset
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             halt,
  output logic [PC_W-2:0]  mem_addr,
  input  logic [INS_W-1:0] mem_rdata,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [INS_W-1:0] ins,
  output logic [PC_W-1:0]  ins_pc
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  ifq_state_e            state;
  logic [PC_W-1:0]       fetch_pc;
  logic                  epoch;
  ifq_tag_t              tag_line [MEM_LAT];
  logic [CNT_W-1:0]      in_flight;
  logic [CNT_W-1:0]      occ;
  logic                  fifo_empty;
  logic [INS_W+PC_W-1:0] head;
  ifq_tag_t              ret_tag;
  logic                  redirect;
  logic                  issue;
  logic                  ret_cur;
  logic                  ret_ok;
  logic                  push;
  logic                  pop;

  assign redirect = redirect_valid && (state != HALTED);
  assign ret_tag  = tag_line[MEM_LAT-1];
  assign ret_cur  = ret_tag.valid && (ret_tag.epoch == epoch);
  assign ret_ok   = ret_cur && !redirect;
  // queued plus outstanding words never exceed DEPTH, so a return always finds room
  assign issue    = (state == RUN) && !halt && !redirect &&
                    ((occ + in_flight) < CNT_W'(DEPTH));
  assign mem_addr = fetch_pc[PC_W-1:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= '0;
      epoch     <= 1'b0;
      in_flight <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_line[i] <= '0;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (halt) state <= HALTED;
        default: state <= state;
      endcase

      if (redirect) begin
        fetch_pc  <= redirect_pc & ~PC_W'(1);
        epoch     <= ~epoch;
        in_flight <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_W'(2);
        in_flight <= in_flight + CNT_W'(issue) - CNT_W'(ret_cur);
      end

      // valids are also cleared on redirect: a 1-bit epoch alone could alias
      // when two redirects land within one read latency
      tag_line[0].valid <= issue;
      tag_line[0].epoch <= epoch;
      tag_line[0].pc    <= fetch_pc;
      for (int i = 1; i < MEM_LAT; i++) begin
        if (redirect) tag_line[i].valid <= 1'b0;
        else          tag_line[i]       <= tag_line[i-1];
      end
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (INS_W + PC_W),
    .CW    (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({mem_rdata, ret_tag.pc}),
    .dout  (head),
    .count (occ),
    .empty (fifo_empty)
  );

`ifdef IFQ_BYPASS_EN
  logic bypass;

  assign bypass    = ret_ok && fifo_empty;
  assign ins_valid = bypass || !fifo_empty;
  assign ins       = bypass ? mem_rdata  : head[INS_W+PC_W-1:PC_W];
  assign ins_pc    = bypass ? ret_tag.pc : head[PC_W-1:0];
  assign push      = ret_ok && !(bypass && ins_ready);
  assign pop       = !fifo_empty && ins_ready && !redirect;
`else
  assign ins_valid = !fifo_empty;
  assign ins       = head[INS_W+PC_W-1:PC_W];
  assign ins_pc    = head[PC_W-1:0];
  assign push      = ret_ok;
  assign pop       = ins_valid && ins_ready && !redirect;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus random ready/redirect traffic
// checked against a program-order stream model (IFQ_BYPASS_EN shortens expected latency by one).
module tb_ifetch_queue;
  localparam int DEPTH   = 4;
  localparam int MEM_LAT = 2;
`ifdef IFQ_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        ins_ready = 1'b0;
  logic [14:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        ins_valid;
  logic [15:0] ins;
  logic [15:0] ins_pc;

  logic [14:0] apipe [MEM_LAT];

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_pc;
  bit          halted_m;
  bit          prev_redir;
  bit          obs_valid;
  logic [15:0] obs_pc;
  logic [15:0] obs_ins;
  int          n_acc;

  ifetch_queue #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_pc         (ins_pc)
  );

  always #5 clk = ~clk;

  // instruction bank: word at address a reads as A000|a, MEM_LAT cycles later
  always @(posedge clk) begin
    apipe[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign mem_rdata = 16'hA000 | {1'b0, apipe[MEM_LAT-1]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one clock cycle: sample at the falling edge, update the stream model, return just after posedge
  task automatic tick();
    @(negedge clk);
    obs_valid = ins_valid;
    if (prev_redir) check("flush_valid", ins_valid, 0);
    prev_redir = 1'b0;
    if (redirect_valid && !halted_m) begin
      exp_pc     = redirect_pc & 16'hFFFE;
      prev_redir = 1'b1;
    end else if (ins_valid && ins_ready) begin
      check("stream_pc", ins_pc, exp_pc);
      check("stream_ins", ins, 16'hA000 | {1'b0, exp_pc[15:1]});
      obs_pc  = ins_pc;
      obs_ins = ins;
      n_acc++;
      exp_pc  = exp_pc + 16'd2;
    end
    if (halt && rst_n) halted_m = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_valid(input int start, output int cyc);
    cyc = start;
    repeat (40) begin
      tick();
      if (obs_valid) return;
      cyc++;
    end
    cyc = -1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          base;
    logic [15:0] tmp;
    exp_pc     = '0;
    halted_m   = 1'b0;
    prev_redir = 1'b0;
    n_acc      = 0;
    obs_pc     = 16'hDEAD;
    obs_ins    = 16'hDEAD;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", ins_valid, 0);
    check("rst_ins", ins, 0);
    check("rst_ins_pc", ins_pc, 0);
    check("rst_mem_addr", mem_addr, 0);

    // 1: sequential stream from reset
    ins_ready = 1'b1;
    rst_n     = 1'b1;
    run_until_valid(0, cyc);
    check("t1_first_cycle", cyc, MEM_LAT + 2 - BYP);
    check("t1_first_pc", obs_pc, 16'h0000);
    check("t1_first_ins", obs_ins, 16'hA000);
    base = n_acc;
    repeat (8) tick();
    check("t1_rate", n_acc - base, 8);

    // 3: redirect while reads are in flight
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    run_until_valid(1, cyc);
    check("t3_redir_lat", cyc, MEM_LAT + 2 - BYP);
    check("t3_pc", obs_pc, 16'h0040);
    check("t3_ins", obs_ins, 16'hA020);
    repeat (6) tick();

    // 2: long stall fills exactly DEPTH entries and stops issuing
    ins_ready = 1'b0;
    repeat (20) tick();
    tmp = exp_pc + 16'(2 * DEPTH);
    check("t2_valid", ins_valid, 1);
    check("t2_mem_addr", mem_addr, tmp[15:1]);
    ins_ready = 1'b1;
    base = n_acc;
    repeat (10) tick();
    check("t2_resume_count", n_acc - base, 10);

    // 4: redirect in the same cycle as a handshake
    ins_ready = 1'b0;
    repeat (2) tick();
    ins_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0041;
    base = n_acc;
    tick();
    redirect_valid = 1'b0;
    check("t4_valid_at_redir", obs_valid, 1);
    check("t4_no_pop", n_acc - base, 0);
    run_until_valid(1, cyc);
    check("t4_redir_lat", cyc, MEM_LAT + 2 - BYP);
    check("t4_pc", obs_pc, 16'h0040);

    // 5: address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    run_until_valid(1, cyc);
    check("t5_pc_top", obs_pc, 16'hFFFE);
    check("t5_ins_top", obs_ins, 16'hFFFF);
    tick();
    check("t5_pc_wrap", obs_pc, 16'h0000);
    check("t5_ins_wrap", obs_ins, 16'hA000);

    // random ready and redirect traffic
    base = n_acc;
    for (int k = 0; k < 800; k++) begin
      ins_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = 16'($urandom);
      tick();
    end
    redirect_valid = 1'b0;
    ins_ready      = 1'b1;
    repeat (10) tick();
    check("rand_progress", (n_acc - base) > 300, 1);

    // 6: halt after three issues
    ins_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    halt = 1'b1;
    repeat (10) tick();
    ins_ready = 1'b1;
    base = n_acc;
    repeat (15) tick();
    check("t6_drain_count", n_acc - base, 3);
    check("t6_valid_after", ins_valid, 0);
    check("t6_mem_addr", mem_addr, 15'h0103);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    check("t6_redir_ignored", ins_valid, 0);
    check("t6_mem_addr_hold", mem_addr, 15'h0103);

    // reset in mid-operation
    halt  = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst2_valid", ins_valid, 0);
    check("rst2_ins_pc", ins_pc, 0);
    check("rst2_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    exp_pc     = '0;
    halted_m   = 1'b0;
    prev_redir = 1'b0;
    rst_n      = 1'b1;
    run_until_valid(0, cyc);
    check("rst2_first_cycle", cyc, MEM_LAT + 2 - BYP);
    check("rst2_first_pc", obs_pc, 16'h0000);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
